bus_mem_slave: RTL and testbench

BUS_MEM_SLAVE -- requirements
Module: bus_mem_slave

---
 rtl/bus_mem_slave_pkg.sv | 16 +
 rtl/bus_mem_array.sv | 25 ++
 rtl/bus_mem_slave.sv | 138 +++++++++++++
 tb/tb_bus_mem_slave.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_slave_pkg.sv
// Shared bus definitions: transaction state encoding and default timing constants
// used by the CPU-side bus interface and every slave.
package bus_mem_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2,
        ST_XFER = 2'd3
    } bus_state_t;

    localparam int BUS_WAIT_CYCLES = 2;
    localparam int BUS_BURST_BEATS = 4;
    localparam int BUS_CNT_W       = 8;

endpackage

// File: rtl/bus_mem_array.sv
// Word storage for the bus memory slave: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module bus_mem_array #(
    parameter int dwidth    = 32,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [dwidth-1:0]    wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [dwidth-1:0]    rdata
);

    logic [dwidth-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_slave.sv
// Memory-mapped bus slave: accepts single or burst transactions, inserts a fixed
// number of wait states after the acceptance pulse, then moves one word per cycle.
//
//   state | meaning
//   IDLE  | no transaction; a request latches address/direction/length
//   ACK   | one-cycle acceptance pulse, data phase not ready
//   WAIT  | WAIT_CYCLES wait states, data phase not ready
//   XFER  | one beat per cycle until the last beat, then back to IDLE
module bus_mem_slave
    import bus_mem_slave_pkg::*;
#(
    parameter int dwidth      = 32,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = BUS_WAIT_CYCLES,
    parameter int BURST_BEATS = BUS_BURST_BEATS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_write,
    input  logic              bus_burst_length,
    input  logic [dwidth-1:0] bus_addr,
    output logic              bus_ack,
    output logic              bus_wait,
    inout  wire  [dwidth-1:0] bus_data
);

    bus_state_t state, state_nxt;

    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic                 single_q;
    logic [BUS_CNT_W-1:0] wait_cnt;
    logic [BUS_CNT_W-1:0] beat_cnt;
    logic                 beat_last;
    logic                 mem_we;
    logic                 data_drive;
    logic [dwidth-1:0]    rdata;

    // Byte-lane bits and bits above the word index carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{bus_addr[dwidth-1:ADDR_BITS+2], bus_addr[1:0]};

    assign beat_last = single_q || (beat_cnt == BUS_CNT_W'(BURST_BEATS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus_req) state_nxt = ST_ACK;
            ST_ACK: begin
                if (!bus_req)             state_nxt = ST_IDLE;
                else if (WAIT_CYCLES > 0) state_nxt = ST_WAIT;
                else                      state_nxt = ST_XFER;
            end
            ST_WAIT: begin
                if (!bus_req)           state_nxt = ST_IDLE;
                else if (wait_cnt == '0) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (!bus_req || beat_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_ack    = 1'b0;
        bus_wait   = 1'b0;
        mem_we     = 1'b0;
        data_drive = 1'b0;
        case (state)
            ST_ACK: begin
                bus_ack  = 1'b1;
                bus_wait = 1'b1;
            end
            ST_WAIT: bus_wait = 1'b1;
            ST_XFER: begin
                // A dropped request aborts before this beat commits.
                mem_we     = write_q && bus_req;
                data_drive = !write_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            single_q <= 1'b0;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_req) begin
                        addr_q   <= bus_addr[ADDR_BITS+1:2];
                        write_q  <= bus_write;
                        single_q <= bus_burst_length;
                        beat_cnt <= '0;
                    end
                end
                ST_ACK:  wait_cnt <= BUS_CNT_W'(WAIT_CYCLES - 1);
                ST_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                ST_XFER: begin
                    if (bus_req) begin
                        addr_q   <= addr_q + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bus_mem_array #(
        .dwidth    (dwidth),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (addr_q),
        .wdata (bus_data),
        .raddr (addr_q),
        .rdata (rdata)
    );

    assign bus_data = data_drive ? rdata : 'z;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: table of transactions plus hand-written
// abort, reset and zero-wait-state sequences.
module tb_bus_mem_slave;

    localparam logic [31:0] SENTINEL = 32'h5A5A_5A5A;

    logic        clk;
    logic        rst_n;
    logic        req, wr, single;
    logic [31:0] addr;
    logic        ack, bwait;
    wire  [31:0] bus_data;
    logic        tb_drv;
    logic [31:0] tb_wdata;

    logic        req0, wr0, single0;
    logic [31:0] addr0;
    logic        ack0, bwait0;
    wire  [31:0] bus_data0;
    logic        tb_drv0;
    logic [31:0] tb_wdata0;

    int checks   = 0;
    int failures = 0;

    assign bus_data  = tb_drv  ? tb_wdata  : 'z;
    assign bus_data0 = tb_drv0 ? tb_wdata0 : 'z;

    bus_mem_slave dut (
        .clk              (clk),
        .reset            (rst_n),
        .bus_req          (req),
        .bus_write        (wr),
        .bus_burst_length (single),
        .bus_addr         (addr),
        .bus_ack          (ack),
        .bus_wait         (bwait),
        .bus_data         (bus_data)
    );

    bus_mem_slave #(.WAIT_CYCLES(0)) dut0 (
        .clk              (clk),
        .reset            (rst_n),
        .bus_req          (req0),
        .bus_write        (wr0),
        .bus_burst_length (single0),
        .bus_addr         (addr0),
        .bus_ack          (ack0),
        .bus_wait         (bwait0),
        .bus_data         (bus_data0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        single;
        logic [31:0] addr;
        logic [31:0] d [4];
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input logic w, input logic s, input logic [31:0] a,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v.wr = w; v.single = s; v.addr = a;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one transaction on the main slave (WAIT_CYCLES=2) and checks its timing and data.
    task automatic run_txn(input int idx);
        vec_t v;
        int   waits, acks, guard, n;
        v = vecs[idx];
        n = v.single ? 1 : 4;
        @(negedge clk);
        req = 1'b1; wr = v.wr; single = v.single; addr = v.addr;
        tb_drv = v.wr; tb_wdata = v.d[0];
        @(negedge clk);
        check($sformatf("v%0d ack_first", idx), {31'b0, ack}, 32'd1);
        waits = 0; acks = 0; guard = 0;
        while (bwait && guard < 20) begin
            waits++;
            if (ack) acks++;
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d wait_cycles", idx), waits, 32'd3);
        check($sformatf("v%0d ack_cycles", idx), acks, 32'd1);
        for (int b = 0; b < n; b++) begin
            check($sformatf("v%0d beat%0d wait", idx, b), {31'b0, bwait}, 32'd0);
            if (v.wr) tb_wdata = v.d[b];
            else      check($sformatf("v%0d beat%0d rdata", idx, b), bus_data, v.d[b]);
            @(negedge clk);
        end
        check($sformatf("v%0d idle_after", idx), {30'b0, ack, bwait}, 32'd0);
        req = 1'b0;
        if (!v.wr) begin
            tb_drv = 1'b1; tb_wdata = SENTINEL;
            #1;
            check($sformatf("v%0d data_z_after", idx), bus_data, SENTINEL);
        end
        tb_drv = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0);
        vecs[1]  = mk(0, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 0, 32'h20,  32'h1, 32'h2, 32'h3, 32'h4);
        vecs[3]  = mk(0, 0, 32'h20,  32'h1, 32'h2, 32'h3, 32'h4);
        vecs[4]  = mk(1, 0, 32'hFF8, 32'h11, 32'h22, 32'h33, 32'h44);
        vecs[5]  = mk(0, 0, 32'hFF8, 32'h11, 32'h22, 32'h33, 32'h44);
        vecs[6]  = mk(0, 1, 32'h0,   32'h33, 0, 0, 0);
        vecs[7]  = mk(0, 1, 32'hFFFF_1007, 32'h44, 0, 0, 0);
        vecs[8]  = mk(0, 1, 32'h2E,  32'h4, 0, 0, 0);
        vecs[9]  = mk(1, 0, 32'h40,  32'h55, 32'h66, 32'h77, 32'h88);
        vecs[10] = mk(0, 0, 32'h40,  32'hA, 32'hB, 32'h77, 32'h88);
        vecs[11] = mk(0, 1, 32'h10,  32'hDEADBEEF, 0, 0, 0);
        vecs[12] = mk(0, 0, 32'h20,  32'h1, 32'h2, 32'h3, 32'h4);

        rst_n = 1'b0;
        req = 0; wr = 0; single = 0; addr = 0;
        req0 = 0; wr0 = 0; single0 = 0; addr0 = 0;
        tb_drv = 1'b1; tb_wdata = SENTINEL;
        tb_drv0 = 1'b0; tb_wdata0 = 0;
        #12;
        check("reset ack/wait", {30'b0, ack, bwait}, 32'd0);
        check("reset data_z", bus_data, SENTINEL);
        @(negedge clk);
        rst_n = 1'b1; tb_drv = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(i);

        // Burst write 0xA..0xD at 0x40, request dropped during the third beat.
        @(negedge clk);
        req = 1; wr = 1; single = 0; addr = 32'h40; tb_drv = 1; tb_wdata = 32'hA;
        @(negedge clk);
        check("abort ack", {31'b0, ack}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort beat0 wait", {31'b0, bwait}, 32'd0);
        tb_wdata = 32'hA;
        @(negedge clk);
        tb_wdata = 32'hB;
        @(negedge clk);
        tb_wdata = 32'hC; req = 0;
        @(negedge clk);
        check("abort idle", {30'b0, ack, bwait}, 32'd0);
        tb_wdata = 32'hD;
        @(negedge clk);
        check("abort stays idle", {30'b0, ack, bwait}, 32'd0);
        tb_drv = 0;

        run_txn(10);

        // Reset asserted while a read sits in its wait states.
        @(negedge clk);
        req = 1; wr = 0; single = 1; addr = 32'h10;
        @(negedge clk);
        check("rst_seq ack", {31'b0, ack}, 32'd1);
        @(negedge clk);
        check("rst_seq in_wait", {30'b0, ack, bwait}, 32'd1);
        tb_drv = 1; tb_wdata = SENTINEL;
        rst_n = 1'b0;
        #1;
        check("rst_seq ack/wait", {30'b0, ack, bwait}, 32'd0);
        check("rst_seq data_z", bus_data, SENTINEL);
        @(negedge clk);
        req = 0; tb_drv = 0; rst_n = 1'b1;

        run_txn(11);
        run_txn(12);

        // Zero-wait-state build: single write, then single read.
        @(negedge clk);
        req0 = 1; wr0 = 1; single0 = 1; addr0 = 32'h30; tb_drv0 = 1; tb_wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        check("w0 write ack", {30'b0, ack0, bwait0}, 32'd3);
        @(negedge clk);
        check("w0 write xfer", {30'b0, ack0, bwait0}, 32'd0);
        @(negedge clk);
        req0 = 0; tb_drv0 = 0;
        @(negedge clk);
        req0 = 1; wr0 = 0; single0 = 1; addr0 = 32'h30;
        @(negedge clk);
        check("w0 read ack", {30'b0, ack0, bwait0}, 32'd3);
        @(negedge clk);
        check("w0 read xfer wait", {31'b0, bwait0}, 32'd0);
        check("w0 read data", bus_data0, 32'hCAFEF00D);
        @(negedge clk);
        check("w0 read idle", {30'b0, ack0, bwait0}, 32'd0);
        req0 = 0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
